icache_refill_unit: RTL and testbench
=====================================

Name: icache_refill_unit

Overview:
- Refill engine directly upstream of riscv_top's temporary L1 instruction-cache refill inputs (RepReady / RepWord).
- On an L1 miss it fetches the line-aligned cache block from a single-outstanding 32-bit backing-memory read port.
- It packs word pairs into 64-bit beats and presents each beat with a one-cycle ready strobe, in ascending address order.

Parameters:
- LINE_BYTES, 64, cache line size in bytes; power of two, ≥ 8.
- ADDR_W, 32, byte-address width.
- BEATS (localparam), LINE_BYTES/8, 64-bit beats per line.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-low reset.
- miss_req_i  in  1  L1 miss request, sampled only in IDLE.
- miss_addr_i  in  ADDR_W  miss byte address; low log2(LINE_BYTES) bits ignored.
- busy_o  out  1  high in every state except IDLE.
- mem_rd_en_o  out  1  one-cycle read request to backing memory.
- mem_addr_o  out  ADDR_W  word-aligned read address, valid while mem_rd_en_o=1.
- mem_rd_valid_i  in  1  read data valid; earliest one cycle after mem_rd_en_o.
- mem_rd_data_i  in  32  read data.
- rep_ready_o  out  1  beat valid strobe; drives riscv_top RepReady.
- rep_word_o  out  64  beat data: [31:0] = lower address word, [63:32] = address+4 word; drives RepWord.
- rep_last_o  out  1  high with the final beat's rep_ready_o.

Behaviour:
- Reset (reset_i=0 at a clk edge):
  - state → IDLE; beat counter, half bit and line base cleared.
  - All outputs 0, including rep_word_o.
  - Applies mid-refill too: the partial line is abandoned and no further strobes are issued. A mem_rd_valid_i arriving after reset is ignored.
- States:
  - IDLE: if miss_req_i=1, latch base = miss_addr_i & ~(LINE_BYTES-1); clear beat_cnt and half; → REQ.
  - REQ: mem_rd_en_o=1, mem_addr_o = base + beat_cnt*8 + half*4, for exactly one cycle; → WAIT. mem_rd_valid_i in REQ is ignored.
  - WAIT: hold until mem_rd_valid_i=1.
    - half=0: capture data into rep_word_o[31:0]; half←1; → REQ.
    - half=1: capture data into rep_word_o[63:32]; half←0; → PUSH.
  - PUSH: rep_ready_o=1 for one cycle; rep_last_o = (beat_cnt == BEATS-1).
    - If last: → IDLE.
    - Otherwise: beat_cnt++; → REQ.
- rep_word_o holds its value between strobes and changes only on capture. Consumers sample it only when rep_ready_o=1.
- Timing with 1-cycle memory latency:
  - Miss sampled at edge 0; first rep_ready_o in cycle 5.
  - One beat every 5 cycles; last beat in cycle 5*BEATS (40 for the default).
  - busy_o falls the cycle after the last PUSH.
- Boundaries:
  - miss_req_i while busy: ignored, not queued.
  - miss_req_i in the same cycle the last PUSH completes: ignored (still busy). It is accepted in the first IDLE cycle.
  - Addresses never cross the line: no carry out of the line offset.
  - Base at top of address space (e.g. 0xFFFF_FFC0) is legal.
  - Arbitrary wait-state counts in WAIT are legal; no timeout.

Decomposition:
- Shared package icache_pkg:
  - refill_state_t enum {IDLE, REQ, WAIT, PUSH}.
  - LINE_BYTES default.
  - Beat width constant REP_WORD_W = 64.
- Single module; no sub-module is warranted. The beat packer is two capture registers inside the FSM.

Test Plan:
- Basic refill: memory returns data = address with 1-cycle latency; miss_addr_i=0x0000_1234 → mem_addr_o sequence 0x1200, 0x1204 … 0x123C. Beat 0 rep_word_o = 0x00001204_00001200; beat 7 = 0x0000123C_00001238 with rep_last_o=1. Exactly 8 strobes; first strobe in cycle 5, last in cycle 40.
- Wait states: 3-cycle memory latency, same request → identical beat data; strobes spaced 9 cycles apart; busy_o stays high throughout.
- Back-to-back: miss 0x1000 is held asserted, then 0x2000 is asserted the cycle busy_o falls → second refill starts with mem_addr_o=0x2000. The held request during refill causes no extra refill.
- Reset mid-refill: reset_i=0 for one cycle after beat 3 → all outputs 0 the next cycle. A stale mem_rd_valid_i is ignored. A new miss at 0x4000 refills cleanly with 8 beats.
- Top-of-memory: miss_addr_i=0xFFFF_FFF8 → base 0xFFFF_FFC0; last mem_addr_o = 0xFFFF_FFFC; no wrap to 0.
- Integration: drive riscv_top RepReady/RepWord from rep_ready_o/rep_word_o → the existing program reaches the store of 25 to address 100.

Source files
------------

// File: rtl/icache_pkg.sv
// ============================================================================
//  icache_pkg
//  Shared types and constants for the L1 instruction-cache refill path.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package icache_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      PUSH = 2'd3
   } refill_state_t;

   localparam int DEFAULT_LINE_BYTES = 64;
   localparam int REP_WORD_W         = 64;

endpackage

`default_nettype wire

// File: rtl/icache_refill_unit.sv
// ============================================================================
//  icache_refill_unit
//  Fetches one cache line over a 32-bit memory port and emits 64-bit beats.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module icache_refill_unit
   import icache_pkg::*;
#(
   parameter int LINE_BYTES = DEFAULT_LINE_BYTES,
   parameter int ADDR_W     = 32
)(
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  miss_req_i,
   input  logic [ADDR_W-1:0]     miss_addr_i,
   output logic                  busy_o,
   output logic                  mem_rd_en_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   input  logic                  mem_rd_valid_i,
   input  logic [31:0]           mem_rd_data_i,
   output logic                  rep_ready_o,
   output logic [REP_WORD_W-1:0] rep_word_o,
   output logic                  rep_last_o
);

   localparam int BEATS = LINE_BYTES / 8;
   localparam int OFF_W = $clog2(LINE_BYTES);
   localparam int CNT_W = (OFF_W > 3) ? OFF_W - 3 : 1;

   localparam logic [CNT_W-1:0]  c_LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [ADDR_W-1:0] c_LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

   refill_state_t     r_state;
   refill_state_t     w_next_state;
   logic [ADDR_W-1:0] r_base;
   logic [CNT_W-1:0]  r_beat_cnt;
   logic              r_half;
   logic [31:0]       r_word_lo;
   logic [31:0]       r_word_hi;
   logic              w_last_beat;
   logic [ADDR_W-1:0] w_offset;

   assign w_last_beat = (r_beat_cnt == c_LAST_BEAT);
   // Base is line aligned, so OR-ing the offset in can never carry out of the line.
   assign w_offset    = (ADDR_W'(r_beat_cnt) << 3) | (ADDR_W'(r_half) << 2);

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         r_state    <= IDLE;
         r_base     <= '0;
         r_beat_cnt <= '0;
         r_half     <= 1'b0;
         r_word_lo  <= '0;
         r_word_hi  <= '0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            IDLE: begin
               if (miss_req_i) begin
                  r_base     <= miss_addr_i & c_LINE_MASK;
                  r_beat_cnt <= '0;
                  r_half     <= 1'b0;
               end
            end
            WAIT: begin
               if (mem_rd_valid_i) begin
                  if (!r_half) begin
                     r_word_lo <= mem_rd_data_i;
                     r_half    <= 1'b1;
                  end else begin
                     r_word_hi <= mem_rd_data_i;
                     r_half    <= 1'b0;
                  end
               end
            end
            PUSH: begin
               if (!w_last_beat) begin
                  r_beat_cnt <= r_beat_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next_state = r_state;
      busy_o       = (r_state != IDLE);
      mem_rd_en_o  = 1'b0;
      mem_addr_o   = '0;
      rep_ready_o  = 1'b0;
      rep_last_o   = 1'b0;
      case (r_state)
         IDLE: begin
            if (miss_req_i) begin
               w_next_state = REQ;
            end
         end
         REQ: begin
            mem_rd_en_o  = 1'b1;
            mem_addr_o   = r_base | w_offset;
            w_next_state = WAIT;
         end
         WAIT: begin
            if (mem_rd_valid_i) begin
               w_next_state = r_half ? PUSH : REQ;
            end
         end
         PUSH: begin
            rep_ready_o  = 1'b1;
            rep_last_o   = w_last_beat;
            w_next_state = w_last_beat ? IDLE : REQ;
         end
         default: w_next_state = IDLE;
      endcase
   end

   assign rep_word_o = {r_word_hi, r_word_lo};

endmodule

`default_nettype wire

// File: tb/tb_icache_refill_unit.sv
// ============================================================================
//  tb_icache_refill_unit
//  Directed self-checking bench for the instruction-cache refill unit.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_icache_refill_unit;
   import icache_pkg::*;

   logic        clk_i       = 1'b0;
   logic        reset_i     = 1'b0;
   logic        miss_req_i  = 1'b0;
   logic [31:0] miss_addr_i = '0;
   logic        busy_o;
   logic        mem_rd_en_o;
   logic [31:0] mem_addr_o;
   logic        mem_rd_valid_i;
   logic [31:0] mem_rd_data_i;
   logic        rep_ready_o;
   logic [63:0] rep_word_o;
   logic        rep_last_o;

   icache_refill_unit #(.LINE_BYTES(64), .ADDR_W(32)) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .miss_req_i     (miss_req_i),
      .miss_addr_i    (miss_addr_i),
      .busy_o         (busy_o),
      .mem_rd_en_o    (mem_rd_en_o),
      .mem_addr_o     (mem_addr_o),
      .mem_rd_valid_i (mem_rd_valid_i),
      .mem_rd_data_i  (mem_rd_data_i),
      .rep_ready_o    (rep_ready_o),
      .rep_word_o     (rep_word_o),
      .rep_last_o     (rep_last_o)
   );

   always #5 clk_i = ~clk_i;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   int t0      = 0;
   int lat     = 1;
   bit inject  = 1'b0;

   // Memory model: returns the read address as data after lat cycles.
   logic        r_pend = 1'b0;
   int          r_dly  = 0;
   logic [31:0] r_paddr = '0;

   always @(posedge clk_i) begin
      cyc <= cyc + 1;
      if (mem_rd_en_o) begin
         r_pend  <= 1'b1;
         r_dly   <= lat - 1;
         r_paddr <= mem_addr_o;
      end else if (r_pend) begin
         if (r_dly != 0) r_dly  <= r_dly - 1;
         else            r_pend <= 1'b0;
      end
   end

   assign mem_rd_valid_i = (r_pend && r_dly == 0) || inject;
   assign mem_rd_data_i  = inject ? 32'hDEAD_BEEF : r_paddr;

   logic [63:0] q_word[$];
   logic        q_last[$];
   int          q_cyc[$];
   logic [31:0] q_addr[$];

   always @(negedge clk_i) begin
      if (rep_ready_o) begin
         q_word.push_back(rep_word_o);
         q_last.push_back(rep_last_o);
         q_cyc.push_back(cyc - t0 + 1);
      end
      if (mem_rd_en_o) q_addr.push_back(mem_addr_o);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic start_miss(input logic [31:0] a, input bit hold);
      @(negedge clk_i);
      miss_addr_i = a;
      miss_req_i  = 1'b1;
      @(posedge clk_i);
      #1;
      t0 = cyc;
      q_word.delete(); q_last.delete(); q_cyc.delete(); q_addr.delete();
      if (!hold) miss_req_i = 1'b0;
   endtask

   task automatic wait_idle(output int fall);
      fall = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk_i);
         if (!busy_o) begin
            fall = cyc - t0 + 1;
            break;
         end
      end
   endtask

   // Checks the logged beats and reads of a full line refill from base.
   task automatic check_line(input string tag, input logic [31:0] base,
                             input int first_cyc, input int spacing);
      logic [31:0] a;
      chk({tag, "_nbeats"}, 64'(q_word.size()), 64'd8);
      chk({tag, "_nreads"}, 64'(q_addr.size()), 64'd16);
      for (int i = 0; i < q_word.size() && i < 8; i++) begin
         a = base + 32'(i * 8);
         chk($sformatf("%s_word%0d", tag, i), q_word[i], {a + 32'd4, a});
         chk($sformatf("%s_last%0d", tag, i), 64'(q_last[i]), 64'(i == 7));
         chk($sformatf("%s_cyc%0d", tag, i), 64'(q_cyc[i]), 64'(first_cyc + i * spacing));
      end
      for (int i = 0; i < q_addr.size() && i < 16; i++) begin
         chk($sformatf("%s_addr%0d", tag, i), 64'(q_addr[i]), 64'(base + 32'(i * 4)));
      end
   endtask

   int fall;
   int n;

   initial begin
      // Reset state
      repeat (3) @(negedge clk_i);
      chk("rst_busy",  64'(busy_o),      64'd0);
      chk("rst_rd_en", 64'(mem_rd_en_o), 64'd0);
      chk("rst_ready", 64'(rep_ready_o), 64'd0);
      chk("rst_word",  rep_word_o,       64'd0);
      chk("rst_last",  64'(rep_last_o),  64'd0);
      reset_i = 1'b1;
      @(negedge clk_i);

      // Basic refill, 1-cycle latency
      lat = 1;
      start_miss(32'h0000_1234, 1'b0);
      wait_idle(fall);
      chk("basic_fall", 64'(fall), 64'd41);
      check_line("basic", 32'h0000_1200, 5, 5);

      // Wait states, 3-cycle latency
      lat = 3;
      start_miss(32'h0000_1234, 1'b0);
      wait_idle(fall);
      chk("ws_fall", 64'(fall), 64'd73);
      check_line("ws", 32'h0000_1200, 9, 9);

      // Back-to-back with a held request
      lat = 1;
      start_miss(32'h0000_1000, 1'b1);
      wait_idle(fall);
      chk("b2b_fall", 64'(fall), 64'd41);
      check_line("b2b_a", 32'h0000_1000, 5, 5);
      miss_addr_i = 32'h0000_2000;
      @(posedge clk_i);
      #1;
      t0 = cyc;
      q_word.delete(); q_last.delete(); q_cyc.delete(); q_addr.delete();
      miss_req_i = 1'b0;
      wait_idle(fall);
      check_line("b2b_b", 32'h0000_2000, 5, 5);
      repeat (4) @(negedge clk_i);
      chk("b2b_no_extra", 64'(busy_o), 64'd0);

      // Reset mid-refill after beat 3
      start_miss(32'h0000_3000, 1'b0);
      n = 0;
      for (int i = 0; i < 200 && n < 4; i++) begin
         @(negedge clk_i);
         if (rep_ready_o) n++;
      end
      chk("mid_beats_seen", 64'(n), 64'd4);
      reset_i = 1'b0;
      @(negedge clk_i);
      chk("mid_busy",  64'(busy_o),      64'd0);
      chk("mid_rd_en", 64'(mem_rd_en_o), 64'd0);
      chk("mid_ready", 64'(rep_ready_o), 64'd0);
      chk("mid_word",  rep_word_o,       64'd0);
      chk("mid_last",  64'(rep_last_o),  64'd0);
      chk("mid_addr",  64'(mem_addr_o),  64'd0);
      reset_i = 1'b1;
      inject  = 1'b1;
      @(negedge clk_i);
      inject  = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("stale_busy", 64'(busy_o),     64'd0);
      chk("stale_word", rep_word_o,      64'd0);
      start_miss(32'h0000_4000, 1'b0);
      wait_idle(fall);
      chk("post_fall", 64'(fall), 64'd41);
      check_line("post", 32'h0000_4000, 5, 5);

      // Top of address space
      start_miss(32'hFFFF_FFF8, 1'b0);
      wait_idle(fall);
      check_line("top", 32'hFFFF_FFC0, 5, 5);
      if (q_addr.size() == 16) chk("top_last_addr", 64'(q_addr[15]), 64'h0000_0000_FFFF_FFFC);
      else chk("top_last_addr_cnt", 64'(q_addr.size()), 64'd16);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
